cycle_count_responder: RTL and testbench
========================================

// Module: cycle_count_responder
// PURPOSE
//  Consumer end of the counterCmd command stream in ddrBenchmark: a hand-written replacement for countCycles_U0.
//  Reads START/STOP/ABORT/END commands from an ap_fifo channel, measures elapsed ap_clk cycles and pushes each result to the out_r FIFO.
//  Exposes *_blk_n stall indicators so the deadlock detector can monitor it like any HLS process.
// PARAMETERS
//  CNT_W  64  counter and result width, bits
//  CMD_W  2   command word width, bits; only bits [1:0] are decoded
// PORTS
//  ap_clk               in   1      clock; all logic on posedge
//  ap_rst               in   1      synchronous, active-high reset
//  ap_start             in   1      block start (ap_ctrl_chain)
//  ap_continue          in   1      acknowledges ap_done
//  ap_done              out  1      run finished; held until ap_continue
//  ap_idle              out  1      high only in IDLE
//  ap_ready             out  1      1-cycle pulse when start is accepted
//  counterCmd_dout      in   CMD_W  command FIFO head: 0=START 1=STOP 2=ABORT 3=END
//  counterCmd_empty_n   in   1      command FIFO non-empty
//  counterCmd_read      out  1      pops the FIFO head this cycle
//  counterCmd_blk_n     out  1      0 = stalled on empty command FIFO
//  out_r_din            out  CNT_W  result value
//  out_r_full_n         in   1      result FIFO has space
//  out_r_write          out  1      pushes out_r_din this cycle
//  out_r_blk_n          out  1      0 = stalled on full result FIFO
//  n_results            out  16     results written this run; wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (ap_rst=1 at posedge):
//   - state=IDLE; cnt=0; n_results=0.
//   - ap_done, ap_ready, counterCmd_read, out_r_write = 0.
//   - ap_idle=1; both blk_n=1; out_r_din=0.
//   - Reset mid-run drops the in-flight count. No partial write is issued.
//  States: IDLE, WAIT_START, COUNTING, WRITE_OUT, DONE.
//  IDLE:
//   - ap_start=1 -> WAIT_START, ap_ready=1 for that cycle, n_results<=0.
//  WAIT_START / COUNTING:
//   - counterCmd_read = counterCmd_empty_n, combinational: exactly one command popped per cycle when available.
//  WAIT_START decode:
//   - START -> COUNTING, cnt<=0.
//   - STOP / ABORT -> discarded, stay.
//   - END -> DONE.
//  COUNTING:
//   - cnt increments every cycle and saturates at all-ones, no wrap.
//   - Result = edges from START pop to STOP pop (t1-t0). START and STOP popped on consecutive cycles give 1.
//  COUNTING decode:
//   - STOP -> latch result into out_r_din, go to WRITE_OUT.
//   - START -> restart: cnt<=0, stay, no write.
//   - ABORT -> WAIT_START, no write.
//   - END -> latch result like STOP and set end_pend; WRITE_OUT.
//  WRITE_OUT:
//   - out_r_write = out_r_full_n; out_r_din held stable.
//   - No command read while in WRITE_OUT.
//   - On write: n_results++; go to DONE if end_pend, else WAIT_START.
//  DONE:
//   - ap_done=1 until ap_continue=1, then IDLE.
//   - ap_continue seen on the same cycle ap_done first rises also completes.
//  Stall indicators:
//   - counterCmd_blk_n = ~(state in {WAIT_START,COUNTING} & ~counterCmd_empty_n).
//   - out_r_blk_n = ~(state==WRITE_OUT & ~out_r_full_n).
//  ap_ready and ap_done are never high in the same cycle. Minimum run: start -> END -> done, ap_done 2 cycles after ap_ready.
// TESTING
//  1. START then STOP one cycle later, out_r_full_n=1 -> one write, out_r_din=1, n_results=1.
//  2. START, 99 empty cycles, STOP -> out_r_din=100; counterCmd_blk_n=0 during the empty cycles.
//  3. START, STOP with out_r_full_n=0 for 5 cycles -> out_r_blk_n=0 5 cycles, no cmd pops, din stable, single write on release.
//  4. START, ABORT, STOP, START, 3 idle cycles, END -> exactly one write (=4); ap_done=1 held until ap_continue; then ap_idle=1.
//  5. CNT_W=4, START, 30 idle cycles, STOP -> out_r_din=4'hF (saturated, no wrap).
//  6. ap_rst asserted in COUNTING -> next cycle IDLE, no out_r_write, n_results=0, ap_idle=1.

Source files
------------

// File: rtl/cycle_count_responder_if.sv
// rtl/cycle_count_responder_if.sv - control, command-FIFO and result-FIFO bundle for cycle_count_responder
//
// Purpose: collects the block-control handshake, the counterCmd read port
// and the out_r write port into one bundle.
// Modports:
//   slave  - the responder: consumes ap_start/ap_continue, command FIFO head
//            and result FIFO space; drives everything else.
//   master - the environment driving the responder (opposite directions).
interface cycle_count_responder_if #(
    parameter int CNT_W = 64,
    parameter int CMD_W = 2
);
    logic             ap_start;
    logic             ap_continue;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic [CMD_W-1:0] counterCmd_dout;
    logic             counterCmd_empty_n;
    logic             counterCmd_read;
    logic             counterCmd_blk_n;
    logic [CNT_W-1:0] out_r_din;
    logic             out_r_full_n;
    logic             out_r_write;
    logic             out_r_blk_n;
    logic [15:0]      n_results;

    modport slave (
        input  ap_start, ap_continue, counterCmd_dout, counterCmd_empty_n, out_r_full_n,
        output ap_done, ap_idle, ap_ready, counterCmd_read, counterCmd_blk_n,
               out_r_din, out_r_write, out_r_blk_n, n_results
    );

    modport master (
        output ap_start, ap_continue, counterCmd_dout, counterCmd_empty_n, out_r_full_n,
        input  ap_done, ap_idle, ap_ready, counterCmd_read, counterCmd_blk_n,
               out_r_din, out_r_write, out_r_blk_n, n_results
    );
endinterface

// File: rtl/cycle_count_responder.sv
// rtl/cycle_count_responder.sv - counterCmd consumer measuring START->STOP cycle distance
//
// Purpose: pops START/STOP/ABORT/END commands, counts ap_clk cycles between a
// START pop and the following STOP (or END) pop, and pushes each result to
// the out_r FIFO. Presents ap_ctrl_chain handshakes and *_blk_n stall flags.
// Ports:
//   ap_clk  - clock, all logic on posedge
//   ap_rst  - synchronous active-high reset
//   bus     - cycle_count_responder_if.slave: ap_start/ap_continue/ap_done/
//             ap_idle/ap_ready, counterCmd FIFO read port, out_r FIFO write
//             port, stall flags and n_results (results written this run)
module cycle_count_responder #(
    parameter int CNT_W = 64,
    parameter int CMD_W = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    cycle_count_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_COUNTING,
        S_WRITE_OUT,
        S_DONE
    } state_t;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_ABORT = 2'd2;
    localparam logic [1:0] CMD_END   = 2'd3;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] din, din_n;
    logic [15:0]      nres, nres_n;
    logic             end_pend, end_pend_n;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       cmd;
    logic             ready_c, done_c, read_c, write_c;

    assign cmd = bus.counterCmd_dout[1:0];

    // Saturating increment: the value the counter holds after this edge, so a
    // STOP popped on the cycle after START reports 1.
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            din      <= '0;
            nres     <= '0;
            end_pend <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            din      <= din_n;
            nres     <= nres_n;
            end_pend <= end_pend_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        din_n      = din;
        nres_n     = nres;
        end_pend_n = end_pend;
        ready_c    = 1'b0;
        done_c     = 1'b0;
        read_c     = 1'b0;
        write_c    = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.ap_start) begin
                    ready_c    = 1'b1;
                    nres_n     = '0;
                    end_pend_n = 1'b0;
                    state_n    = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                read_c = bus.counterCmd_empty_n;
                if (bus.counterCmd_empty_n) begin
                    case (cmd)
                        CMD_START: begin
                            cnt_n   = '0;
                            state_n = S_COUNTING;
                        end
                        CMD_END:  state_n = S_DONE;
                        default:  ;
                    endcase
                end
            end
            S_COUNTING: begin
                cnt_n  = cnt_inc;
                read_c = bus.counterCmd_empty_n;
                if (bus.counterCmd_empty_n) begin
                    case (cmd)
                        CMD_STOP: begin
                            din_n   = cnt_inc;
                            state_n = S_WRITE_OUT;
                        end
                        CMD_START: cnt_n   = '0;
                        CMD_ABORT: state_n = S_WAIT_START;
                        CMD_END: begin
                            din_n      = cnt_inc;
                            end_pend_n = 1'b1;
                            state_n    = S_WRITE_OUT;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE_OUT: begin
                write_c = bus.out_r_full_n;
                if (bus.out_r_full_n) begin
                    nres_n     = nres + 16'd1;
                    end_pend_n = 1'b0;
                    state_n    = end_pend ? S_DONE : S_WAIT_START;
                end
            end
            S_DONE: begin
                done_c = 1'b1;
                if (bus.ap_continue) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Strobes are suppressed while reset is asserted so a reset landing in
    // WRITE_OUT never leaks a partial write or a command pop.
    assign bus.ap_ready        = ready_c & ~ap_rst;
    assign bus.ap_done         = done_c  & ~ap_rst;
    assign bus.counterCmd_read = read_c  & ~ap_rst;
    assign bus.out_r_write     = write_c & ~ap_rst;
    assign bus.ap_idle         = (state == S_IDLE);
    assign bus.out_r_din       = din;
    assign bus.n_results       = nres;

    assign bus.counterCmd_blk_n = ~(((state == S_WAIT_START) || (state == S_COUNTING))
                                    && !bus.counterCmd_empty_n);
    assign bus.out_r_blk_n      = ~((state == S_WRITE_OUT) && !bus.out_r_full_n);
endmodule

// File: tb/tb_cycle_count_responder.sv
// tb/tb_cycle_count_responder.sv - directed vector bench for cycle_count_responder
module tb_cycle_count_responder;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    cycle_count_responder_if #(.CNT_W(64), .CMD_W(2)) bus ();
    cycle_count_responder_if #(.CNT_W(4),  .CMD_W(2)) bus4 ();

    assign bus4.ap_start           = bus.ap_start;
    assign bus4.ap_continue        = bus.ap_continue;
    assign bus4.counterCmd_dout    = bus.counterCmd_dout;
    assign bus4.counterCmd_empty_n = bus.counterCmd_empty_n;
    assign bus4.out_r_full_n       = bus.out_r_full_n;

    cycle_count_responder #(.CNT_W(64), .CMD_W(2)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    cycle_count_responder #(.CNT_W(4), .CMD_W(2)) dut4 (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus4)
    );

    int checks = 0;
    int failures = 0;
    int wr_count = 0;

    always @(negedge ap_clk) begin
        if (bus.out_r_write) wr_count <= wr_count + 1;
    end

    typedef struct {
        int          gap;
        int          stall;
        logic [63:0] exp_din;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic start_run();
        bus.ap_start = 1'b1;
        #1;
        chk("ap_ready_on_start", bus.ap_ready, 1);
        tick();
        bus.ap_start = 1'b0;
        #1;
        chk("ap_idle_after_start", bus.ap_idle, 0);
    endtask

    task automatic push_cmd(input logic [1:0] c);
        bus.counterCmd_dout    = c;
        bus.counterCmd_empty_n = 1'b1;
        #1;
        chk("cmd_read", bus.counterCmd_read, 1);
        tick();
        bus.counterCmd_empty_n = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus.counterCmd_empty_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (i == 0 || i == n - 1) chk("cmd_blk_n_empty", bus.counterCmd_blk_n, 0);
            tick();
        end
    endtask

    task automatic finish_run();
        bus.ap_continue = 1'b1;
        #1;
        chk("ap_done_at_continue", bus.ap_done, 1);
        tick();
        bus.ap_continue = 1'b0;
        #1;
        chk("ap_idle_after_done", bus.ap_idle, 1);
    endtask

    initial begin
        int wr_before;

        vecs[0] = '{gap: 0,  stall: 0, exp_din: 64'd1};
        vecs[1] = '{gap: 99, stall: 0, exp_din: 64'd100};
        vecs[2] = '{gap: 0,  stall: 5, exp_din: 64'd1};
        vecs[3] = '{gap: 2,  stall: 1, exp_din: 64'd3};
        vecs[4] = '{gap: 7,  stall: 0, exp_din: 64'd8};

        bus.ap_start           = 1'b0;
        bus.ap_continue        = 1'b0;
        bus.counterCmd_dout    = 2'd0;
        bus.counterCmd_empty_n = 1'b0;
        bus.out_r_full_n       = 1'b1;
        ap_rst = 1'b1;
        tick();
        tick();
        chk("rst_idle",      bus.ap_idle, 1);
        chk("rst_done",      bus.ap_done, 0);
        chk("rst_ready",     bus.ap_ready, 0);
        chk("rst_write",     bus.out_r_write, 0);
        chk("rst_read",      bus.counterCmd_read, 0);
        chk("rst_cmd_blk",   bus.counterCmd_blk_n, 1);
        chk("rst_out_blk",   bus.out_r_blk_n, 1);
        chk("rst_din",       bus.out_r_din, 0);
        chk("rst_n_results", bus.n_results, 0);
        ap_rst = 1'b0;
        tick();

        // Minimum run: ready, END, done two cycles after ready; continue on rise.
        start_run();
        chk("wait_ready_low", bus.ap_ready, 0);
        push_cmd(2'd3);
        #1;
        chk("min_done",       bus.ap_done, 1);
        chk("min_ready_low",  bus.ap_ready, 0);
        finish_run();
        chk("min_no_write",   wr_count, 0);

        // Table: START, gap, STOP, optional back-pressure.
        start_run();
        foreach (vecs[v]) begin
            push_cmd(2'd0);
            idle_cycles(vecs[v].gap);
            bus.out_r_full_n = (vecs[v].stall == 0);
            push_cmd(2'd1);
            bus.counterCmd_dout    = 2'd0;
            bus.counterCmd_empty_n = 1'b1;
            for (int s = 0; s < vecs[v].stall; s++) begin
                #1;
                chk("stall_out_blk_n", bus.out_r_blk_n, 0);
                chk("stall_no_write",  bus.out_r_write, 0);
                chk("stall_no_pop",    bus.counterCmd_read, 0);
                chk("stall_din",       bus.out_r_din, vecs[v].exp_din);
                tick();
            end
            bus.counterCmd_empty_n = 1'b0;
            bus.out_r_full_n       = 1'b1;
            #1;
            chk("vec_write",   bus.out_r_write, 1);
            chk("vec_din",     bus.out_r_din, vecs[v].exp_din);
            chk("vec_out_blk", bus.out_r_blk_n, 1);
            tick();
            chk("vec_n_results", bus.n_results, 64'(v + 1));
            chk("vec_wr_count",  wr_count, 64'(v + 1));
        end
        push_cmd(2'd3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("done_held",  bus.ap_done, 1);
            chk("done_ready", bus.ap_ready, 0);
            tick();
        end
        finish_run();

        // START, ABORT, STOP, START, 3 idle, END -> single write of 4.
        wr_before = wr_count;
        start_run();
        chk("run_n_results_clear", bus.n_results, 0);
        push_cmd(2'd0);
        push_cmd(2'd2);
        push_cmd(2'd1);
        push_cmd(2'd0);
        idle_cycles(3);
        push_cmd(2'd3);
        #1;
        chk("end_write", bus.out_r_write, 1);
        chk("end_din",   bus.out_r_din, 4);
        tick();
        chk("end_done",  bus.ap_done, 1);
        chk("end_one_write", wr_count - wr_before, 1);
        chk("end_n_results", bus.n_results, 1);
        tick();
        tick();
        chk("end_done_held", bus.ap_done, 1);
        finish_run();

        // Saturation on the 4-bit instance: 31 cycles -> 4'hF.
        start_run();
        push_cmd(2'd0);
        idle_cycles(30);
        push_cmd(2'd1);
        #1;
        chk("sat_write4", bus4.out_r_write, 1);
        chk("sat_din4",   bus4.out_r_din, 4'hF);
        chk("sat_din64",  bus.out_r_din, 31);
        tick();
        push_cmd(2'd3);
        finish_run();

        // Reset while COUNTING after one result already written.
        start_run();
        push_cmd(2'd0);
        push_cmd(2'd1);
        tick();
        chk("pre_rst_n_results", bus.n_results, 1);
        push_cmd(2'd0);
        idle_cycles(3);
        wr_before = wr_count;
        ap_rst = 1'b1;
        #1;
        chk("rst_cnt_no_write", bus.out_r_write, 0);
        tick();
        ap_rst = 1'b0;
        chk("rst_cnt_idle",   bus.ap_idle, 1);
        chk("rst_cnt_nres",   bus.n_results, 0);
        chk("rst_cnt_din",    bus.out_r_din, 0);
        chk("rst_cnt_writes", wr_count - wr_before, 0);

        // Reset landing on the WRITE_OUT cycle must suppress the write.
        start_run();
        push_cmd(2'd0);
        push_cmd(2'd1);
        ap_rst = 1'b1;
        #1;
        chk("rst_wr_no_write", bus.out_r_write, 0);
        tick();
        ap_rst = 1'b0;
        #1;
        chk("rst_wr_idle",   bus.ap_idle, 1);
        chk("rst_wr_writes", wr_count - wr_before, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
